dot_product_accumulator: RTL and testbench



---
 rtl/dot_product_accumulator_pkg.sv | 25 ++
 rtl/dot_product_accumulator_sat_adder.sv | 33 +++
 rtl/dot_product_accumulator.sv | 114 +++++++++++
 tb/tb_dot_product_accumulator.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_accumulator_pkg.sv
// Shared definitions for the multiplier datapath: FSM encoding, product width
// and accumulator clamp limits.
`default_nettype none

package dot_product_accumulator_pkg;

  localparam int PROD_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic longint acc_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  function automatic longint acc_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/dot_product_accumulator_sat_adder.sv
// Combinational saturating adder: acc + sign-extended product, clamped to the
// signed ACC_W range, with an overflow indication.
`default_nettype none

module dot_product_accumulator_sat_adder
  import dot_product_accumulator_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int PROD_W = PROD_W_DEF
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic signed [PROD_W-1:0] i_prod,
  output logic signed [ACC_W-1:0]  o_sum,
  output logic                     o_ovf
);

  localparam logic signed [ACC_W-1:0] c_ACC_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic signed [ACC_W-1:0] c_ACC_MIN = ACC_W'(acc_min(ACC_W));

  logic [ACC_W:0] w_sum;

  assign w_sum = {i_acc[ACC_W-1], i_acc}
               + {{(ACC_W + 1 - PROD_W){i_prod[PROD_W-1]}}, i_prod};

  // The extra bit and the result sign disagree exactly when the true sum
  // falls outside the ACC_W signed range; the extra bit gives the direction.
  assign o_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign o_sum = !o_ovf       ? $signed(w_sum[ACC_W-1:0]) :
                 w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX;

endmodule

`default_nettype wire

// File: rtl/dot_product_accumulator.sv
// Accumulates a programmed number of signed products into a saturating
// accumulator and presents the sum on a valid/ready result port.
`default_nettype none

module dot_product_accumulator
  import dot_product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic [LEN_W-1:0]         i_vec_len,
  input  logic                     i_prod_valid,
  input  logic signed [PROD_W-1:0] i_prod,
  output logic                     o_busy,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic signed [ACC_W-1:0]  o_result,
  output logic                     o_overflow
);

  state_t                  r_state;
  state_t                  w_state_next;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_result;
  logic [LEN_W-1:0]        r_count;
  logic [LEN_W-1:0]        r_len;
  logic                    r_overflow;

  logic signed [ACC_W-1:0] w_sum;
  logic                    w_ovf;
  logic                    w_take;
  logic                    w_last;

  dot_product_accumulator_sat_adder #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_adder (
    .i_acc  (r_acc),
    .i_prod (i_prod),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  assign w_take = (r_state == ST_ACCUM) && i_prod_valid;
  assign w_last = w_take && (r_count == r_len - LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = (i_vec_len != '0) ? ST_ACCUM : ST_HOLD;
        end
      end
      ST_ACCUM: begin
        if (w_last) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_res_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_result   <= '0;
      r_count    <= '0;
      r_len      <= '0;
      r_overflow <= 1'b0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_len      <= i_vec_len;
      r_overflow <= 1'b0;
      if (i_vec_len == '0) begin
        r_result <= '0;
      end
    end else if (w_take) begin
      // Keep accumulating from the clamped value so later products can recover.
      r_acc      <= w_sum;
      r_count    <= r_count + LEN_W'(1);
      r_overflow <= r_overflow | w_ovf;
      if (w_last) begin
        r_result <= w_sum;
      end
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_res_valid = (r_state == ST_HOLD);
  assign o_result    = r_result;
  assign o_overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_dot_product_accumulator.sv
// Directed self-checking bench for dot_product_accumulator (ACC_W = 20).
`default_nettype none

module tb_dot_product_accumulator;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 20;
  localparam int LEN_W  = 8;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     i_start = 1'b0;
  logic [LEN_W-1:0]         i_vec_len = '0;
  logic                     i_prod_valid = 1'b0;
  logic signed [PROD_W-1:0] i_prod = '0;
  logic                     o_busy;
  logic                     o_res_valid;
  logic                     i_res_ready = 1'b0;
  logic signed [ACC_W-1:0]  o_result;
  logic                     o_overflow;

  int checks = 0;
  int errors = 0;

  dot_product_accumulator #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_vec_len    (i_vec_len),
    .i_prod_valid (i_prod_valid),
    .i_prod       (i_prod),
    .o_busy       (o_busy),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_result     (o_result),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input int len);
    i_start   = 1'b1;
    i_vec_len = LEN_W'(len);
    cyc();
    i_start   = 1'b0;
  endtask

  task automatic handshake();
    i_res_ready = 1'b1;
    cyc();
    i_res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_res_valid !== 1'b0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b valid=%b ovf=%b required 0 0 0", o_busy, o_res_valid, o_overflow);
    end
    checks++;
    if (o_result !== '0) begin
      errors++;
      $display("FAIL reset_result got %0d required 0", o_result);
    end
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_basic_sum();
    int p[4] = '{100, -50, 32767, -32768};
    start_vec(4);
    checks++;
    if (o_busy !== 1'b1 || o_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_accum_state busy=%b valid=%b required 1 0", o_busy, o_res_valid);
    end
    for (int i = 0; i < 4; i++) begin
      i_prod_valid = 1'b1;
      i_prod       = PROD_W'(p[i]);
      cyc();
      if (i == 2) begin
        checks++;
        if (o_res_valid !== 1'b0) begin
          errors++;
          $display("FAIL basic_early_valid got %b required 0", o_res_valid);
        end
      end
    end
    i_prod_valid = 1'b0;
    checks++;
    if (o_res_valid !== 1'b1 || o_result !== 20'sd49 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_result valid=%b result=%0d ovf=%b required 1 49 0", o_res_valid, o_result, o_overflow);
    end
    handshake();
    checks++;
    if (o_res_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_return_idle valid=%b busy=%b required 0 0", o_res_valid, o_busy);
    end
  endtask

  task automatic test_gaps_backpressure();
    start_vec(3);
    for (int i = 0; i < 3; i++) begin
      i_prod_valid = 1'b1;
      i_prod       = PROD_W'(10 * (i + 1));
      cyc();
      i_prod_valid = 1'b0;
      if (i < 2) begin
        repeat (2) cyc();
      end
    end
    checks++;
    if (o_res_valid !== 1'b1 || o_result !== 20'sd60) begin
      errors++;
      $display("FAIL gaps_result valid=%b result=%0d required 1 60", o_res_valid, o_result);
    end
    for (int k = 0; k < 5; k++) begin
      i_start      = (k == 1);
      i_vec_len    = 8'd5;
      i_prod_valid = (k == 2);
      i_prod       = 16'sd1234;
      cyc();
      i_start      = 1'b0;
      i_prod_valid = 1'b0;
      checks++;
      if (o_res_valid !== 1'b1 || o_result !== 20'sd60) begin
        errors++;
        $display("FAIL stall_hold cycle=%0d valid=%b result=%0d required 1 60", k, o_res_valid, o_result);
      end
    end
    handshake();
    checks++;
    if (o_res_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL gaps_return_idle valid=%b busy=%b required 0 0", o_res_valid, o_busy);
    end
    cyc();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_start_ignored busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_reset_mid_op();
    start_vec(4);
    i_prod_valid = 1'b1;
    i_prod       = 16'sd5;
    cyc();
    i_prod       = 16'sd7;
    cyc();
    i_prod_valid = 1'b0;
    reset        = 1'b1;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_res_valid !== 1'b0 || o_result !== '0) begin
      errors++;
      $display("FAIL midop_reset busy=%b valid=%b result=%0d required 0 0 0", o_busy, o_res_valid, o_result);
    end
    cyc();
    reset = 1'b0;
    start_vec(1);
    i_prod_valid = 1'b1;
    i_prod       = 16'sd9;
    cyc();
    i_prod_valid = 1'b0;
    checks++;
    if (o_res_valid !== 1'b1 || o_result !== 20'sd9 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_result valid=%b result=%0d ovf=%b required 1 9 0", o_res_valid, o_result, o_overflow);
    end
    handshake();
  endtask

  task automatic test_saturation();
    start_vec(20);
    i_prod_valid = 1'b1;
    i_prod       = 16'sd32767;
    repeat (20) cyc();
    i_prod_valid = 1'b0;
    checks++;
    if (o_res_valid !== 1'b1 || o_result !== 20'sh7FFFF || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos valid=%b result=%0d ovf=%b required 1 524287 1", o_res_valid, o_result, o_overflow);
    end
    handshake();

    start_vec(20);
    i_prod_valid = 1'b1;
    i_prod       = -16'sd32768;
    repeat (20) cyc();
    i_prod_valid = 1'b0;
    checks++;
    if (o_res_valid !== 1'b1 || o_result !== 20'sh80000 || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg valid=%b result=%0d ovf=%b required 1 -524288 1", o_res_valid, o_result, o_overflow);
    end
    handshake();

    start_vec(1);
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_cleared_on_start got %b required 0", o_overflow);
    end
    i_prod_valid = 1'b1;
    i_prod       = 16'sd1;
    cyc();
    i_prod_valid = 1'b0;
    checks++;
    if (o_result !== 20'sd1 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL post_clear_result result=%0d ovf=%b required 1 0", o_result, o_overflow);
    end
    handshake();

    // 17 x 32767 clamps to 524287; a following -32768 pulls back to 491519.
    start_vec(18);
    i_prod_valid = 1'b1;
    i_prod       = 16'sd32767;
    repeat (17) cyc();
    i_prod       = -16'sd32768;
    cyc();
    i_prod_valid = 1'b0;
    checks++;
    if (o_res_valid !== 1'b1 || o_result !== 20'sd491519 || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_recover valid=%b result=%0d ovf=%b required 1 491519 1", o_res_valid, o_result, o_overflow);
    end
    handshake();
  endtask

  task automatic test_zero_length();
    start_vec(0);
    checks++;
    if (o_res_valid !== 1'b1 || o_result !== '0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL zero_len valid=%b result=%0d ovf=%b required 1 0 0", o_res_valid, o_result, o_overflow);
    end
    i_prod_valid = 1'b1;
    i_prod       = 16'sd500;
    repeat (2) cyc();
    i_prod_valid = 1'b0;
    checks++;
    if (o_res_valid !== 1'b1 || o_result !== '0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_prod_ignored valid=%b result=%0d ovf=%b required 1 0 0", o_res_valid, o_result, o_overflow);
    end
    handshake();
    checks++;
    if (o_res_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_idle valid=%b busy=%b required 0 0", o_res_valid, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_gaps_backpressure();
    test_reset_mid_op();
    test_saturation();
    test_zero_length();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
